pwm_duty_cmd: RTL
=================

// Module: pwm_duty_cmd
// PURPOSE
//  Front end of the PWM controller: takes the raw increase/decrease push-buttons, synchronises and
//  debounces them, and maintains the saturating duty-cycle command (0..DUTY_MAX) consumed by the
//  PWM counter/comparator stage. Adds hold-to-repeat stepping. One duty_upd pulse per applied change.
// PARAMETERS
//  DUTY_W        4   width of duty command
//  DUTY_MAX      10  upper saturation value (100 % at PWM period 10)
//  DUTY_INIT     5   duty value after reset
//  DEBOUNCE_CYC  4   consecutive stable cycles before debounced level changes (>=1)
//  REPEAT_DLY    8   cycles held after first step before auto-repeat starts (>=1)
//  REPEAT_RATE   4   cycles between auto-repeat steps (>=1)
// PORTS
//  clk       in   1       single clock; all logic on rising edge
//  rst       in   1       reset, synchronous, active-high
//  ena       in   1       block enable; low = no stepping
//  btn_inc   in   1       raw async increase button, active-high
//  btn_dec   in   1       raw async decrease button, active-high
//  duty      out  DUTY_W  current duty command to PWM stage
//  duty_upd  out  1       1-cycle pulse in the cycle duty shows a new value
//  at_max    out  1       duty == DUTY_MAX
//  at_min    out  1       duty == 0
// BEHAVIOUR
//  - Interface decision: one clock; reset is synchronous and active-high.
//  - Reset: duty=DUTY_INIT, duty_upd=0, at_max/at_min from DUTY_INIT. Sync flops, debounced levels,
//    and counters are 0. FSM=IDLE. Reset mid-press: no step until the button is released and re-pressed.
//  - Each button: 2-FF synchroniser, then debounce. A counter counts consecutive cycles where the
//    synced level != debounced level. It clears on agreement. The debounced level flips when the
//    count reaches DEBOUNCE_CYC. Rise pulse = debounced 0->1.
//  - Latency: a clean input rise at cycle 0 appears as a duty change at cycle 2+DEBOUNCE_CYC+1.
//  - FSM states IDLE, HOLD, REPEAT, LOCK:
//    IDLE: rise on exactly one button -> step once, go HOLD, reload timer=REPEAT_DLY.
//    HOLD: button still debounced-high, timer expires -> step, go REPEAT, timer=REPEAT_RATE.
//    REPEAT: step every REPEAT_RATE cycles while held.
//    HOLD/REPEAT: release -> IDLE. Other button rises -> LOCK.
//    Both debounced high in IDLE (simultaneous) -> LOCK, no step. LOCK -> IDLE only when both low.
//  - Step: inc gives duty+1 saturating at DUTY_MAX; dec gives duty-1 saturating at 0. Compare in
//    DUTY_W+1 bits; no wrap. duty_upd fires only if the value changed, so a step at a limit gives
//    no pulse.
//  - ena=0: debounce keeps running, FSM forced IDLE, no steps, duty held. When ena returns to 1 with
//    a button held, no step occurs until release and re-press.
//  - duty, duty_upd, at_max, at_min are registered outputs; no combinational path from inputs.
// CONFIGURATION
//  PWM_DUTY_AUTOREPEAT_EN defined: full FSM as above.
//  Not defined: HOLD never times out and REPEAT is unreachable. Behaviour is one step per press;
//    LOCK rules are unchanged. REPEAT_DLY and REPEAT_RATE are ignored.
// STRUCTURE
//  - pwm_pkg: FSM state enum (2 bits) and a shared DUTY_W default used by this block and the PWM stage.
//  - Sub-module pwm_btn_debounce (synchroniser, debounce counter, debounced level, rise pulse),
//    instantiated twice. The top holds the FSM, repeat timer, and duty register.
// TESTING (defaults; latency 7 cycles)
//  1. Reset, then idle -> duty=5, at_max=0, at_min=0, duty_upd never asserts.
//  2. btn_inc high 20 cycles with 2-cycle glitches beforehand -> glitches produce no change;
//     clean press gives duty 5->6 with duty_upd 7 cycles after the edge (autorepeat off).
//  3. Autorepeat on, hold btn_inc 60 cycles -> steps at edge+7, then +8, then every 4 cycles.
//     Reaches 10, at_max=1, no further duty_upd.
//  4. From duty=0, press btn_dec -> duty stays 0, at_min=1, no duty_upd.
//  5. Both buttons rise in the same cycle -> no step (LOCK); release dec only -> still no step;
//     release both then press inc -> one step.
//  6. Assert rst while btn_inc is held in REPEAT -> duty=5 next cycle; no step until re-press.
//     ena=0 during a press -> duty frozen.

Source files
------------

// File: rtl/pwm_pkg.sv
// Types and defaults shared between the duty-command front end and the PWM counter stage.
package pwm_pkg;

  localparam int DUTY_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } btn_fsm_e;

endpackage

// File: rtl/pwm_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and debounced level with registered rise pulse.
// Rise pulse is registered in the same cycle the debounced level turns high (2 + DEBOUNCE_CYC cycles after input).
module pwm_btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic clr_arm_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q, rise_q, armed_q;
  logic             flip_d;

  assign flip_d = (sync2_q != level_q) && (cnt_q == CNT_LAST);

  // A rise only counts once the button has been seen released after reset or
  // after being pressed while the block was disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (flip_d) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      rise_q <= flip_d && sync2_q && armed_q;
      if (clr_arm_i && sync2_q) begin
        armed_q <= 1'b0;
      end else if (vld_q[1] && !sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pwm_duty_cmd.sv
// Saturating duty command driven by debounced inc/dec buttons; hold-to-repeat when PWM_DUTY_AUTOREPEAT_EN is defined.
// A clean press reaches duty 3 + DEBOUNCE_CYC cycles after the input edge; all outputs are registered.
module pwm_duty_cmd
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int DUTY_MAX     = 10,
  parameter int DUTY_INIT    = 5,
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_DLY   = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic              btn_inc_i,
  input  logic              btn_dec_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_upd_o,
  output logic              at_max_o,
  output logic              at_min_o
);

`ifdef PWM_DUTY_AUTOREPEAT_EN
  localparam logic AUTOREP = 1'b1;
`else
  localparam logic AUTOREP = 1'b0;
`endif

  localparam int TMR_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]  TMR_DLY  = TMR_W'(REPEAT_DLY);
  localparam logic [TMR_W-1:0]  TMR_RATE = TMR_W'(REPEAT_RATE);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [DUTY_W:0]   MAX_EXT  = (DUTY_W + 1)'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] MAX_V    = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_V   = DUTY_W'(DUTY_INIT);

  logic inc_lvl, inc_rise, dec_lvl, dec_rise;

  pwm_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .btn_i    (btn_inc_i),
    .clr_arm_i(!ena_i),
    .level_o  (inc_lvl),
    .rise_o   (inc_rise)
  );

  pwm_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .btn_i    (btn_dec_i),
    .clr_arm_i(!ena_i),
    .level_o  (dec_lvl),
    .rise_o   (dec_rise)
  );

  btn_fsm_e          state_q;
  logic              dir_up_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [DUTY_W-1:0] duty_q;
  logic              upd_q, at_max_q, at_min_q;

  logic              held_lvl, other_rise, expire;
  logic              step_vld_d, step_up_d;
  logic [DUTY_W:0]   duty_ext, inc_ext, dec_ext;
  logic [DUTY_W-1:0] duty_d;

  assign held_lvl   = dir_up_q ? inc_lvl  : dec_lvl;
  assign other_rise = dir_up_q ? dec_rise : inc_rise;
  assign expire     = AUTOREP && (tmr_q == TMR_ONE);

  // Step request decode; saturation is done one bit wider so nothing wraps.
  always_comb begin
    step_vld_d = 1'b0;
    step_up_d  = dir_up_q;
    if (ena_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!(inc_lvl && dec_lvl)) begin
            if (inc_rise) begin
              step_vld_d = 1'b1;
              step_up_d  = 1'b1;
            end else if (dec_rise) begin
              step_vld_d = 1'b1;
              step_up_d  = 1'b0;
            end
          end
        end
        ST_HOLD, ST_REPEAT: step_vld_d = !other_rise && held_lvl && expire;
        default:            step_vld_d = 1'b0;
      endcase
    end
    duty_ext = {1'b0, duty_q};
    inc_ext  = (duty_ext >= MAX_EXT) ? MAX_EXT : duty_ext + 1'b1;
    dec_ext  = (duty_ext == '0) ? '0 : duty_ext - 1'b1;
    duty_d   = step_up_d ? inc_ext[DUTY_W-1:0] : dec_ext[DUTY_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      dir_up_q <= 1'b0;
      tmr_q    <= '0;
      duty_q   <= INIT_V;
      upd_q    <= 1'b0;
      at_max_q <= (INIT_V == MAX_V);
      at_min_q <= (INIT_V == '0);
    end else begin
      upd_q <= step_vld_d && (duty_d != duty_q);
      if (step_vld_d) begin
        duty_q   <= duty_d;
        at_max_q <= (duty_d == MAX_V);
        at_min_q <= (duty_d == '0);
      end
      if (!ena_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (inc_lvl && dec_lvl) begin
              state_q <= ST_LOCK;
            end else if (step_vld_d) begin
              state_q  <= ST_HOLD;
              dir_up_q <= step_up_d;
              tmr_q    <= TMR_DLY;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (other_rise) begin
              state_q <= ST_LOCK;
            end else if (!held_lvl) begin
              state_q <= ST_IDLE;
            end else if (step_vld_d) begin
              state_q <= ST_REPEAT;
              tmr_q   <= TMR_RATE;
            end else if (tmr_q != '0) begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          ST_LOCK: begin
            if (!inc_lvl && !dec_lvl) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign duty_o     = duty_q;
  assign duty_upd_o = upd_q;
  assign at_max_o   = at_max_q;
  assign at_min_o   = at_min_q;

endmodule
